// File: rtl/timer_irq_ctrl_if.sv
// MEM-stage data bus seen by the timer: strobes, address and write data in, read data back
// in the same cycle.
interface timer_irq_ctrl_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output rd,
    output wr,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  rd,
    input  wr,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Memory-mapped reloading timer with interrupt status plus a free-running systick counter.
// Register reads are combinational; writes land on the next clk edge.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE     = 32'h4000_0000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  timer_irq_ctrl_if.slave  bus,
  output logic             irqout
);

  localparam int unsigned    PsW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

  logic [31:0]    th_q, th_d;
  logic [31:0]    tl_q, tl_d;
  logic [31:0]    systick_q, systick_d;
  logic           en_q, en_d;
  logic           ie_q, ie_d;
  logic           is_q, is_d;
  logic [PsW-1:0] ps_q, ps_d;

  logic sel_th, sel_tl, sel_tcon, sel_systick;
  logic in_window;
  logic wr_th, wr_tl, wr_tcon, wr_systick;
  logic step, overflow;

  // Only word-aligned accesses inside the 32-byte window can hit.
  assign in_window = (bus.addr[31:5] == BASE[31:5]) && (bus.addr[1:0] == 2'b00);

  always_comb begin
    sel_th      = 1'b0;
    sel_tl      = 1'b0;
    sel_tcon    = 1'b0;
    sel_systick = 1'b0;
    if (in_window) begin
      case (bus.addr[4:2])
        3'd0:    sel_th      = 1'b1;
        3'd1:    sel_tl      = 1'b1;
        3'd2:    sel_tcon    = 1'b1;
        3'd5:    sel_systick = 1'b1;
        default: ;
      endcase
    end
  end

  assign wr_th      = bus.wr & sel_th;
  assign wr_tl      = bus.wr & sel_tl;
  assign wr_tcon    = bus.wr & sel_tcon;
  assign wr_systick = bus.wr & sel_systick;

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.rd) begin
      if (sel_th)      bus.rdata = th_q;
      if (sel_tl)      bus.rdata = tl_q;
      if (sel_tcon)    bus.rdata = {29'h0, is_q, ie_q, en_q};
      if (sel_systick) bus.rdata = systick_q;
    end
  end

  // With PRESCALE == 1 the count never leaves 0, so step follows EN directly.
  assign step     = en_q && (ps_q == PsMax);
  assign overflow = step && (tl_q == 32'hFFFF_FFFF) && !wr_tl;

  always_comb begin
    ps_d = (!en_q || step) ? '0 : ps_q + 1'b1;

    th_d = wr_th ? bus.wdata : th_q;

    tl_d = tl_q;
    if (wr_tl)         tl_d = bus.wdata;
    else if (overflow) tl_d = th_q;
    else if (step)     tl_d = tl_q + 32'd1;

    en_d = wr_tcon ? bus.wdata[0] : en_q;
    ie_d = wr_tcon ? bus.wdata[1] : ie_q;
    // An overflow coinciding with a software clear must not be lost.
    is_d = (wr_tcon ? bus.wdata[2] : is_q) | (overflow & ie_d);

    systick_d = wr_systick ? bus.wdata : systick_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= 32'h0;
      tl_q      <= 32'h0;
      systick_q <= 32'h0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      is_q      <= 1'b0;
      ps_q      <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      systick_q <= systick_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      is_q      <= is_d;
      ps_q      <= ps_d;
    end
  end

  assign irqout = ie_q & is_q;

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
Memory-mapped timer and interrupt source on the CPU's MEM-stage data bus. It consumes the MEM-stage rd/wr/addr/wdata and returns rdata in the same cycle. It produces the irqout level that the ID-stage Control unit samples to divert to the exception vector. It also provides a free-running systick counter for software timing.

Parameters:
BASE, 32'h40000000, byte base address of the register window
PRESCALE, 1, clk cycles per TL increment (integer >= 1)

Ports:
clk  input  1  core clock (divided clock, same as pipeline registers)
reset  input  1  asynchronous, active-low reset
rd  input  1  MEM-stage read strobe
wr  input  1  MEM-stage write strobe
addr  input  32  MEM-stage byte address (ALU result)
wdata  input  32  MEM-stage store data
rdata  output  32  read data, combinational
irqout  output  1  interrupt request level to Control

Behaviour:
- Reset: reset is asynchronous and active-low; clock is clk. While reset=0, all of the following are 0 immediately, and irqout=0 combinationally: TH, TL, TCON[2:0], SYSTICK, prescaler count.
- Register map (offset from BASE, word aligned):
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON: bit0 EN, bit1 IE, bit2 IS (status); bits 31:3 read 0.
  - 0x14 SYSTICK: R/W.
- Address decoding:
  - An access hits only if addr[31:5]==BASE[31:5], addr[1:0]==0, and the offset is listed above.
  - Any other address: writes are ignored and rdata=0.
- Reads:
  - rdata is combinational with zero latency.
  - rdata = selected register when rd=1 and the address hits; otherwise rdata=0.
  - A read returns the pre-edge value, even if a write hits in the same cycle.
- Writes: take effect at the posedge clk when wr=1 and the address hits. rd and wr may both be high; the read sees the old value.
- Prescaler:
  - When EN=1: counts 0..PRESCALE-1 and wraps; step=1 on the cycle the count equals PRESCALE-1.
  - When EN=0: held at 0.
  - If PRESCALE=1, step=EN every cycle.
- TL update priority per posedge:
  1. A write to TL loads wdata. Step, reload and overflow are suppressed that cycle.
  2. Else if step and TL==32'hFFFFFFFF: TL<=TH, and overflow=1.
  3. Else if step: TL<=TL+1, 32-bit wrap-free.
  4. Else hold.
- TCON update:
  - A write to TCON loads bits [2:0] from wdata; bits 31:3 are ignored.
  - IS_next = (write ? wdata[2] : IS) | (overflow & IE_next). This means an overflow in the same cycle as a write that sets IE=1 still sets IS.
  - Software clears IS by writing TCON with bit2=0. If an overflow coincides with that write, IS stays 1 (the event is not lost).
- irqout = IE & IS, registered-state derived with no extra latency. It rises on the clk edge after the cycle in which TL wraps, i.e. the same edge at which TL shows the TH reload.
- SYSTICK:
  - Increments every clk regardless of EN, wrapping FFFFFFFF->0.
  - A write loads wdata; that cycle's increment is suppressed.
- EN cleared mid-count: TL freezes at its current value and the prescaler resets to 0. On re-enable, counting resumes from the frozen TL with a full PRESCALE interval before the first step.
- Reset asserted mid-operation: all state is cleared immediately. A pending IS is lost by design.

Test Plan:
1. Reset:
   - Stimulus: hold reset=0 for 3 cycles, then release.
   - Required: reads of 0x40000000, 0x40000004, 0x40000008 and 0x40000014 return 0, and irqout=0. SYSTICK reads 1, 2, 3 on the following cycles.
2. Wrap with IRQ (PRESCALE=1):
   - Stimulus: write TH=FFFFFFFD, TL=FFFFFFFE, TCON=3.
   - Required: TL reads FFFFFFFF, then FFFFFFFD. TCON reads 7 and irqout=1 on the same edge as the reload. TL then continues FFFFFFFE, FFFFFFFF, FFFFFFFD.
3. Clear IRQ:
   - Stimulus: from the end of scenario 2, write TCON=3.
   - Required: irqout=0 next cycle, then re-asserts after the next wrap (3 steps later). Writing TCON=1 (IE=0) while the timer wraps keeps irqout=0 with IS=0.
4. Simultaneous events:
   - Stimulus A: write TL=5 on the wrap cycle. Required: TL=5 and IS stays 0.
   - Stimulus B: write TCON=3 (clear IS) on a wrap cycle. Required: TCON reads 7 and irqout=1.
5. PRESCALE=4 instance:
   - Stimulus: TL=0, TCON=1.
   - Required: TL increments once every 4 cycles (0,0,0,0,1,...). Clearing EN freezes TL. Re-enabling gives the first increment 4 cycles later.
6. Decode and reset mid-run:
   - Stimulus A: read 0x4000000C, 0x40000006 and 0x40000020, and write to each.
   - Required A: rdata=0 and no register changes.
   - Stimulus B: assert reset=0 asynchronously between edges while irqout=1.
   - Required B: irqout and all registers drop to 0 before the next edge.
